// File: rtl/vm_pkg.sv
// vm_pkg: states, coin/change encodings and unit values shared by the vending machine
package vm_pkg;
  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;
  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5 = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_20 = 2'd3;
  localparam logic [1:0] CHG_NONE = 2'd0;
  localparam logic [1:0] CHG_5 = 2'd1;
  localparam logic [1:0] CHG_10 = 2'd2;
  localparam int UNIT_5 = 1;
  localparam int UNIT_10 = 2;
  localparam int UNIT_20 = 4;
  function automatic int coin_units(logic [1:0] c);
    return c == COIN_20 ? UNIT_20 : c == COIN_10 ? UNIT_10 : c == COIN_5 ? UNIT_5 : 0;
  endfunction
  function automatic int change_units(logic [1:0] c);
    return c == CHG_10 ? UNIT_10 : c == CHG_5 ? UNIT_5 : 0;
  endfunction
endpackage

// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: pays out an amount as 10rs coins first, then a final 5rs coin
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] amount,
  output logic [1:0]   change,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remaining
);
  logic [1:0] coin;
  assign coin = amount >= W'(2) ? CHG_10 : amount != '0 ? CHG_5 : CHG_NONE;
  assign remaining = amount - W'(change_units(coin));
  assign done = busy && amount == '0;
  always_ff @(posedge clk)
    if (rst) begin
      change <= CHG_NONE;
      busy <= 1'b0;
    end else begin
      change <= (load || busy) ? coin : CHG_NONE;
      busy <= load || (busy && amount != '0);
    end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item coin vending FSM with change return; define VM_STOCK_EN for per-item stock
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 6,
  parameter int STOCK_W = 4,
  parameter int BASE_PRICE = 3,
  parameter int STEP_PRICE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   in,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel,
  input  logic                         cancel,
  input  logic                         restock,
  output logic                         out,
  output logic [$clog2(NUM_ITEMS)-1:0] out_item,
  output logic [1:0]                   change,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         busy,
  output logic                         err
);
  state_t state, state_n;
  logic [CREDIT_W:0] sum;
  logic [CREDIT_W-1:0] eff, amount, remaining, credit_n;
  logic ovf, in_stock, sel_ok, load, done, out_n, err_n, ignored;
  int price;

  // eff is the credit including this cycle's coin, unless that coin overflows
  assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_units(in));
  assign ovf = sum[CREDIT_W];
  assign eff = ovf ? credit : sum[CREDIT_W-1:0];
  assign price = BASE_PRICE + int'(sel) * STEP_PRICE;
  assign sel_ok = int'(sel) < NUM_ITEMS && int'(eff) >= price && in_stock;
  assign amount = state == COLLECT ? eff : credit;
  assign ignored = in != COIN_NONE || sel_valid;

  always_comb begin
    state_n = state;
    credit_n = credit;
    load = 1'b0;
    out_n = 1'b0;
    err_n = 1'b0;
    case (state)
      COLLECT: begin
        credit_n = eff;
        err_n = ovf;
        if (cancel) begin
          if (eff != '0) begin
            load = 1'b1;
            credit_n = remaining;
            state_n = CHANGE;
          end
        end else if (sel_valid) begin
          if (sel_ok) begin
            out_n = 1'b1;
            credit_n = CREDIT_W'(int'(eff) - price);
            state_n = VEND;
          end else err_n = 1'b1;
        end
      end
      VEND: begin
        err_n = ignored;
        load = credit != '0;
        credit_n = remaining;
        state_n = load ? CHANGE : COLLECT;
      end
      CHANGE: begin
        err_n = ignored;
        credit_n = remaining;
        state_n = done ? COLLECT : CHANGE;
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= COLLECT;
      credit <= '0;
      out <= 1'b0;
      out_item <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      out <= out_n;
      out_item <= out_n ? sel : '0;
      err <= err_n;
    end

`ifdef VM_STOCK_EN
  logic [STOCK_W-1:0] stock [NUM_ITEMS];
  assign in_stock = stock[sel] != '0;
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_ITEMS; i++)
      if (rst || (state == COLLECT && restock)) stock[i] <= '1;
      else if (out_n && int'(sel) == i) stock[i] <= stock[i] - STOCK_W'(1);
`else
  logic [STOCK_W-1:0] unused_stock;
  assign in_stock = 1'b1;
  assign unused_stock = {STOCK_W{restock}};
`endif

  vm_change_dispenser #(.W(CREDIT_W)) u_chg (
    .clk(clk),
    .rst(rst),
    .load(load),
    .amount(amount),
    .change(change),
    .busy(busy),
    .done(done),
    .remaining(remaining)
  );
endmodule
